// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst reader (and the planned burst writer).
//   AXI_BURST_INCR     : ARBURST/AWBURST encoding for incrementing bursts
//   AXI_RESP_OKAY      : RRESP/BRESP encoding for a good response
//   AXI_BOUNDARY_BYTES : bursts may not cross this address boundary
//   axi_size()         : bytes-per-beat -> AxSIZE encoding
//   rd_state_e         : read master FSM states
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
  localparam int         AXI_BOUNDARY_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } rd_state_e;

  // log2 of a power-of-two byte count (1..128) as a 3-bit AxSIZE.
  function automatic logic [2:0] axi_size(input int bytes);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) s = i;
    end
    return 3'(s);
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing: the largest INCR burst that fits in the request
// remainder, the per-burst beat cap, and the space left before the next 4 KB
// boundary.
//   i_addr_low  : low 12 bits of the burst start address (beat aligned)
//   i_remaining : beats still to be requested
//   o_burst     : beats for this burst (1..MAX_BURST_LEN when i_remaining != 0)
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_BURST_LEN  = 16,
  parameter int BYTES_PER_BEAT = 4
) (
  input  logic [11:0]          i_addr_low,
  input  logic [LEN_WIDTH-1:0] i_remaining,
  output logic [8:0]           o_burst
);

  localparam int SIZE = int'(axi_size(BYTES_PER_BEAT));

  logic [12:0] w_to_4k;
  logic [12:0] w_min;

  // Bytes to the boundary, converted to beats. Aligned start keeps this exact.
  assign w_to_4k = (13'(AXI_BOUNDARY_BYTES) - {1'b0, i_addr_low}) >> SIZE;

  always_comb begin
    w_min = 13'(MAX_BURST_LEN);
    if (w_to_4k < w_min) w_min = w_to_4k;
    if (32'(i_remaining) < 32'(w_min)) w_min = 13'(i_remaining);
  end

  assign o_burst = 9'(w_min);

endmodule

// File: rtl/axi_master_burst_reader.sv
// AXI4 read master: splits one request (start, target_addr, target_beats) into
// INCR bursts capped at MAX_BURST_LEN that never cross a 4 KB boundary, and
// streams the read data out with backpressure.
//   clk, rst          : clock, asynchronous active-high reset
//   start/target_*    : request strobe, start byte address, total beats (0 = no-op)
//   busy/done/err     : request in flight, completion pulse, error flag valid with done
//   AR*               : AXI read-address channel (one burst outstanding)
//   R*                : AXI read-data channel
//   out_*             : output stream; out_last marks the final beat of the request
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; a valid source holds its payload stable until that edge.
module axi_master_burst_reader
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  input  logic [LEN_WIDTH-1:0]  target_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RLAST,
  input  logic [1:0]            RRESP,
  output logic                  RREADY,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int         BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE  = axi_size(BYTES);

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [8:0]            r_burst;
  logic [7:0]            r_arlen;
  logic [8:0]            r_beat_cnt;
  logic                  r_err;

  logic [8:0]            w_calc_burst;
  logic                  w_in_data;
  logic                  w_r_hs;
  logic                  w_last_hs;
  logic                  w_final;
  logic                  w_beat_err;
  logic [ADDR_WIDTH-1:0] w_burst_bytes;

  axi_burst_calc #(
    .LEN_WIDTH      (LEN_WIDTH),
    .MAX_BURST_LEN  (MAX_BURST_LEN),
    .BYTES_PER_BEAT (BYTES)
  ) u_calc (
    .i_addr_low  (r_addr[11:0]),
    .i_remaining (r_remaining),
    .o_burst     (w_calc_burst)
  );

  assign w_in_data     = (r_state == ST_DATA);
  assign w_r_hs        = w_in_data & RVALID & out_ready;
  assign w_last_hs     = w_r_hs & RLAST;
  // This burst covers everything left in the request.
  assign w_final       = (32'(r_remaining) <= 32'(r_burst));
  // Bad response, or RLAST not landing on the beat ARLEN promised.
  assign w_beat_err    = (RRESP != AXI_RESP_OKAY) | (RLAST ^ (r_beat_cnt == r_burst - 9'd1));
  assign w_burst_bytes = ADDR_WIDTH'(r_burst) << SIZE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = (target_beats != '0) ? ST_CALC : ST_DONE;
      ST_CALC: w_next = ST_ADDR;
      ST_ADDR: if (ARREADY) w_next = ST_DATA;
      // A burst closes only on RLAST, even if the beat count disagrees.
      ST_DATA: if (w_last_hs) w_next = w_final ? ST_DONE : ST_CALC;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_burst     <= '0;
      r_arlen     <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (target_beats != '0) begin
              r_addr      <= target_addr;
              r_remaining <= target_beats;
            end
          end
        end
        ST_CALC: begin
          r_burst <= w_calc_burst;
          r_arlen <= 8'(w_calc_burst - 9'd1);
        end
        ST_ADDR: begin
          if (ARREADY) r_beat_cnt <= '0;
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_beat_err) r_err <= 1'b1;
            if (RLAST) begin
              r_addr      <= r_addr + w_burst_bytes;
              r_remaining <= w_final ? '0 : r_remaining - LEN_WIDTH'(r_burst);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == ST_CALC) | (r_state == ST_ADDR) | w_in_data;
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;

  assign ARVALID   = (r_state == ST_ADDR);
  assign ARADDR    = r_addr;
  assign ARLEN     = r_arlen;
  assign ARSIZE    = SIZE;
  assign ARBURST   = AXI_BURST_INCR;

  // R channel passes straight through to the stream so backpressure is lossless.
  assign RREADY    = w_in_data & out_ready;
  assign out_valid = w_in_data & RVALID;
  assign out_data  = RDATA;
  assign out_last  = w_in_data & RVALID & RLAST & (32'(r_remaining) == 32'(r_burst));

endmodule
